// File: rtl/sha_nonce_checker.sv
// sha_nonce_checker
//   Sits behind the two-stage SHA-256 pipeline. The pipeline carries no nonce
//   tag, so this block rebuilds each digest's nonce from its in-order
//   position. Every digest is compared against a target mask, and the nonces
//   of hits are queued in a small FIFO. Control logic drains the FIFO over a
//   valid/ready handshake.
//
// Ports
//   CLK          clock, all logic on posedge
//   RST          asynchronous active-high reset
//   start        one-cycle pulse that loads a new job
//   nonce_base   nonce of the first digest of the job (sampled on start)
//   job_len      number of digests in the job, 0 means 2^CNT_W (sampled on start)
//   target_mask  a digest is a hit iff (digest_in & target_mask) == 0
//   in_valid     digest strobe from the pipeline
//   digest_in    digest from the pipeline
//   out_valid    hit FIFO is non-empty
//   out_nonce    nonce at the FIFO head
//   out_ready    pops the head when out_valid && out_ready
//   busy         job running
//   done         job finished
//   overflow     sticky: at least one hit was dropped because the FIFO was full
//   hit_count    hits seen this job, dropped ones included; saturates at all-ones
module sha_nonce_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] nonce_base,
    input  logic [CNT_W-1:0] job_len,
    input  logic [255:0]     target_mask,
    input  logic             in_valid,
    input  logic [255:0]     digest_in,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_nonce,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] hit_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [CNT_W-1:0]   nonce_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [255:0]       mask_reg;
    logic [CNT_W-1:0]   hit_count_reg;
    logic               overflow_reg;

    logic [CNT_W-1:0]   mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;

    logic accept;
    logic hit;
    logic fifo_full;
    logic pop;
    logic push;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, since a slot frees up at that edge.
    always_comb begin
        accept    = (state_reg == RUN) && in_valid;
        hit       = accept && ~|(digest_in & mask_reg);
        fifo_full = (count_reg == DEPTH_C);
        pop       = (count_reg != '0) && out_ready;
        push      = hit && (!fifo_full || pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            nonce_reg     <= '0;
            remaining_reg <= '0;
            mask_reg      <= '0;
            hit_count_reg <= '0;
            overflow_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (start) begin
            // A new job wins over any same-cycle digest, push or pop.
            state_reg     <= RUN;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            nonce_reg     <= nonce_base;
            remaining_reg <= job_len;
            mask_reg      <= target_mask;
            hit_count_reg <= '0;
            overflow_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push) begin
                mem_reg[wr_ptr_reg] <= nonce_reg;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase

            if (hit) begin
                if (hit_count_reg != '1) begin
                    hit_count_reg <= hit_count_reg + CNT_W'(1);
                end
                if (!push) begin
                    overflow_reg <= 1'b1;
                end
            end

            if (accept) begin
                nonce_reg     <= nonce_reg + CNT_W'(1);
                // A job_len of 0 wraps to all-ones here, giving 2^CNT_W digests.
                remaining_reg <= remaining_reg - CNT_W'(1);
                if (remaining_reg == CNT_W'(1)) begin
                    state_reg <= DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
            end
        end
    end

    assign out_valid = (count_reg != '0);
    assign out_nonce = mem_reg[rd_ptr_reg];
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;
    assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_sha_nonce_checker.sv
module tb_sha_nonce_checker;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  nonce_base = '0;
    logic [31:0]  job_len = '0;
    logic [255:0] target_mask = '0;
    logic         in_valid = 1'b0;
    logic [255:0] digest_in = '0;
    logic         out_valid;
    logic [31:0]  out_nonce;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [31:0]  hit_count;

    int n_pass = 0;
    int n_total = 0;

    sha_nonce_checker #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .nonce_base(nonce_base),
        .job_len(job_len), .target_mask(target_mask), .in_valid(in_valid),
        .digest_in(digest_in), .out_valid(out_valid), .out_nonce(out_nonce),
        .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow),
        .hit_count(hit_count)
    );

    always #5 CLK = ~CLK;

    localparam logic [255:0] MASK_TOP32 = {32'hFFFF_FFFF, 224'h0};
    localparam logic [255:0] DG_HIT_A   = {32'h0000_0000, 32'hDEAD_DEAD, 192'h1};
    localparam logic [255:0] DG_MISS    = {32'h1234_5678, 32'hAAAA_5555, 192'h2};
    localparam logic [255:0] DG_HIT_B   = {32'h0000_0000, 32'hBEEF_BEEF, 192'h3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s act=%08h exp=%08h", name, act, exp);
        end else begin
            $display("FAIL %s act=%08h exp=%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and leave time 1 past the edge.
    task automatic step(input logic st, input logic iv, input logic [255:0] dg, input logic rdy);
        start     = st;
        in_valid  = iv;
        digest_in = dg;
        out_ready = rdy;
        @(posedge CLK);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic new_job(input logic [31:0] base, input logic [31:0] len,
                           input logic [255:0] mask, input logic rdy);
        nonce_base  = base;
        job_len     = len;
        target_mask = mask;
        step(1'b1, 1'b0, '0, rdy);
    endtask

    typedef struct {
        logic         st;
        logic         iv;
        logic [255:0] dg;
        logic         rdy;
        logic         e_valid;
        logic [31:0]  e_nonce;
        logic [31:0]  e_hits;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Basic job: base 0x1000, len 3, top-32 mask, always ready.
        vecs[0] = '{1'b1, 1'b0, 256'h0,   1'b1, 1'b0, 32'h0,    32'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, DG_HIT_A, 1'b1, 1'b1, 32'h1000, 32'd1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, DG_MISS,  1'b1, 1'b0, 32'h0,    32'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, DG_HIT_B, 1'b1, 1'b1, 32'h1002, 32'd2, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 256'h0,   1'b1, 1'b0, 32'h0,    32'd2, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, DG_HIT_A, 1'b1, 1'b0, 32'h0,    32'd2, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_nonce", out_nonce, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // in_valid in IDLE is ignored
        step(1'b0, 1'b1, DG_HIT_A, 1'b0);
        step(1'b0, 1'b1, DG_HIT_B, 1'b0);
        chk("idle_hit_count", hit_count, 32'd0);
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Table-driven basic job
        nonce_base  = 32'h1000;
        job_len     = 32'd3;
        target_mask = MASK_TOP32;
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].st, vecs[i].iv, vecs[i].dg, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid)
                chk($sformatf("vec%0d_nonce", i), out_nonce, vecs[i].e_nonce);
            chk($sformatf("vec%0d_hits", i), hit_count, vecs[i].e_hits);
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
            chk($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, vecs[i].e_done});
        end

        // Gapped input: digest every 3rd cycle
        new_job(32'h1000, 32'd3, MASK_TOP32, 1'b1);
        for (int k = 0; k < 9; k++) begin
            logic [255:0] dg;
            dg = (k == 2) ? DG_HIT_A : (k == 5) ? DG_MISS : DG_HIT_B;
            step(1'b0, (k % 3) == 2, dg, 1'b1);
            chk($sformatf("gap%0d_busy", k), {31'b0, busy}, {31'b0, (k != 8)});
            chk($sformatf("gap%0d_valid", k), {31'b0, out_valid}, {31'b0, (k == 2 || k == 8)});
            if (k == 2) chk("gap_nonce0", out_nonce, 32'h1000);
            if (k == 8) chk("gap_nonce1", out_nonce, 32'h1002);
        end
        chk("gap_hit_count", hit_count, 32'd2);
        chk("gap_done", {31'b0, done}, 32'd1);

        // Overflow: 6 hits into a 4-deep FIFO with no drain
        new_job(32'h1000, 32'd6, 256'h0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, DG_MISS, 1'b0);
        chk("ovf_overflow", {31'b0, overflow}, 32'd1);
        chk("ovf_hit_count", hit_count, 32'd6);
        chk("ovf_done", {31'b0, done}, 32'd1);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("ovf_head_stable", out_nonce, 32'h1000);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_pop%0d_nonce", k), out_nonce, 32'h1000 + k);
            step(1'b0, 1'b0, '0, 1'b1);
            chk($sformatf("ovf_pop%0d_valid", k), {31'b0, out_valid}, {31'b0, (k < 3)});
        end

        // Full FIFO with simultaneous pop while a hit arrives
        new_job(32'h1000, 32'd5, 256'h0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, DG_MISS, 1'b0);
        step(1'b0, 1'b1, DG_MISS, 1'b1);
        chk("fp_overflow", {31'b0, overflow}, 32'd0);
        chk("fp_hit_count", hit_count, 32'd5);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fp_pop%0d_nonce", k), out_nonce, 32'h1001 + k);
            step(1'b0, 1'b0, '0, 1'b1);
        end
        chk("fp_empty", {31'b0, out_valid}, 32'd0);

        // Nonce wrap
        new_job(32'hFFFF_FFFE, 32'd3, 256'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, DG_HIT_A, 1'b0);
        chk("wrap_done", {31'b0, done}, 32'd1);
        chk("wrap_n0", out_nonce, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_n1", out_nonce, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_n2", out_nonce, 32'h0000_0000);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_empty", {31'b0, out_valid}, 32'd0);

        // job_len 0 means 2^32: still running after a few digests
        new_job(32'h0, 32'd0, MASK_TOP32, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, DG_MISS, 1'b1);
        chk("len0_busy", {31'b0, busy}, 32'd1);
        chk("len0_done", {31'b0, done}, 32'd0);

        // Restart during RUN flushes FIFO and clears status; start beats in_valid
        new_job(32'h1000, 32'd10, 256'h0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, DG_MISS, 1'b0);
        chk("rs_pre_overflow", {31'b0, overflow}, 32'd1);
        nonce_base = 32'h2000;
        step(1'b1, 1'b1, DG_MISS, 1'b0);
        chk("rs_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_overflow", {31'b0, overflow}, 32'd0);
        chk("rs_hit_count", hit_count, 32'd0);
        chk("rs_busy", {31'b0, busy}, 32'd1);
        step(1'b0, 1'b1, DG_MISS, 1'b0);
        chk("rs_nonce", out_nonce, 32'h2000);
        chk("rs_hit_count1", hit_count, 32'd1);

        // Async reset mid-RUN with 2 hits queued
        new_job(32'h1000, 32'd10, 256'h0, 1'b0);
        step(1'b0, 1'b1, DG_MISS, 1'b0);
        step(1'b0, 1'b1, DG_MISS, 1'b0);
        chk("ar_pre_hits", hit_count, 32'd2);
        #2 RST = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_hit_count", hit_count, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        step(1'b0, 1'b1, DG_HIT_A, 1'b0);
        step(1'b0, 1'b1, DG_HIT_A, 1'b0);
        chk("ar_idle_hits", hit_count, 32'd0);
        chk("ar_idle_valid", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
